serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built around one full_adder instance and a carry flip-flop.
//  Accepts a parallel operand pair, adds one bit per clock (LSB first), then presents a
//  parallel sum and carry-out with a done pulse. Area-cheap replacement for a ripple-carry
//  adder where throughput is not critical; feeds the full_adder cell its a/b/cin each cycle.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range 2..32
// PORTS
//  clk    in   1      single clock, all state updates on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request: sample a, b, cin and begin an addition
//  a      in   WIDTH  operand A (sampled only when start accepted)
//  b      in   WIDTH  operand B (sampled only when start accepted)
//  cin    in   1      carry-in (sampled only when start accepted)
//  busy   out  1      high while bits are being added
//  done   out  1      one-cycle pulse: sum/cout valid
//  sum    out  WIDTH  result bits, held until next accepted start
//  cout   out  1      final carry-out, held with sum
// BEHAVIOUR
//  - Reset: one clock with rst=1 -> state IDLE; busy=0, done=0, sum=0, cout=0, count=0,
//    carry FF=0. rst wins over every other input, including in the middle of RUN.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: start=1 -> load A-shift<=a, B-shift<=b, carry<=cin, count<=0 -> RUN.
//          start=0 -> stay.
//    RUN:  each cycle, full_adder inputs = A-shift[0], B-shift[0], carry.
//          The sum bit shifts into the result register from the MSB end
//          (res <= {s, res[WIDTH-1:1]}). carry<=fa cout; A/B shift right; count<=count+1.
//          When count==WIDTH-1 (last bit) -> DONE. start is ignored in RUN.
//    DONE: done=1 for exactly this cycle; sum=result register, cout=carry FF.
//          start=1 -> accepted (same load as IDLE) -> RUN. start=0 -> IDLE.
//  - busy=1 iff state==RUN (registered, state-decoded). done=1 iff state==DONE.
//  - Latency: start sampled high on edge k -> busy high on cycles k+1..k+WIDTH ->
//    done high on cycle k+WIDTH+1. Throughput: one add per WIDTH+1 cycles back-to-back.
//  - sum/cout update only on entry to DONE, then hold through IDLE and any later RUN
//    until the next DONE. During RUN they show the previous result, never partial bits.
//  - Arithmetic: {cout,sum} == a + b + cin modulo 2^(WIDTH+1); no overflow flag.
//  - count is $clog2(WIDTH) bits wide; it never wraps within an operation.
//  - Operand inputs may change freely after the start edge; only the latched copies are used.
// TESTING (WIDTH=8 unless noted)
//  1. a=8'h12,b=8'h34,cin=0,start 1 cycle -> busy 8 cycles, done at start+9,
//     sum=8'h46, cout=0.
//  2. a=8'hFF,b=8'h01,cin=0 -> sum=8'h00, cout=1. Then a=8'h5A,b=8'hA5,cin=1 ->
//     sum=8'h00, cout=1.
//  3. Start held high for 20 cycles with a=8'h01,b=8'h01,cin=0 -> second add accepted on
//     the done cycle; done pulses at cycles 9 and 18; sum=8'h02 each time.
//  4. Pulse start mid-RUN with different operands -> ignored; result is that of the
//     first operands.
//  5. Assert rst at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0;
//     no done pulse follows.
//  6. Exhaustive: WIDTH=4, all a,b,cin (512 cases) vs a+b+cin -> zero mismatches.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master drives the request and operands; the slave returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry flop.
// Bits are processed LSB first, one per clock; the parallel result is
// published only when the last bit is done, together with a one-cycle pulse.

// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ash;     // operand A, shifted right each bit
  logic [WIDTH-1:0] bsh;     // operand B, shifted right each bit
  // Holds the WIDTH-1 sum bits produced so far; the final bit comes straight
  // from the cell on the last cycle, so a full-width register is not needed.
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    count;
  logic             carry;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_nxt;

  full_adder u_fa (
    .a    (ash[0]),
    .b    (bsh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // New sum bit enters at the top; after the last bit this is the full sum.
  assign res_nxt = {fa_s, res};

  // Control FSM with registered status and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ash    <= '0;
      bsh    <= '0;
      res    <= '0;
      count  <= '0;
      carry  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            ash    <= bus.a;
            bsh    <= bus.b;
            carry  <= bus.cin;
            count  <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res   <= res_nxt[WIDTH-1:1];
          carry <= fa_co;
          ash   <= ash >> 1;
          bsh   <= bsh >> 1;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            sum_r  <= res_nxt;
            cout_r <= fa_co;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            ash    <= bus.a;
            bsh    <= bus.b;
            carry  <= bus.cin;
            count  <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for timing/feature
// scenarios and a 4-bit instance for the exhaustive sweep.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  // Launch one 8-bit add and wait (bounded) for done; operands are scrambled
  // right after the start edge. lat counts negedges after the start edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output logic [7:0] s, output logic co,
                        output int lat, output int bcnt);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = ci;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = ~a; bus8.b = ~b; bus8.cin = ~ci;
    lat  = 1;
    bcnt = int'(bus8.busy);
    while (!bus8.done && lat < 40) begin
      @(negedge clk);
      lat++;
      bcnt += int'(bus8.busy);
    end
    s  = bus8.sum;
    co = bus8.cout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus8.busy); end
    checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus8.done); end
    checks++; if (bus8.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h exp 00", bus8.sum); end
    checks++; if (bus8.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", bus8.cout); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] s; logic co; int lat, bcnt;
    run_op(8'h12, 8'h34, 1'b0, s, co, lat, bcnt);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d exp 9", lat); end
    checks++; if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bcnt); end
    checks++; if (s !== 8'h46) begin errors++; $display("FAIL basic_sum got %h exp 46", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout got %b exp 0", co); end
    @(negedge clk);
    checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", bus8.done); end
    checks++; if (bus8.sum !== 8'h46) begin errors++; $display("FAIL basic_sum_hold got %h exp 46", bus8.sum); end
  endtask

  task automatic test_carry();
    logic [7:0] s; logic co; int lat, bcnt;
    logic [7:0] va [4] = '{8'hFF, 8'h5A, 8'h80, 8'h7F};
    logic [7:0] vb [4] = '{8'h01, 8'hA5, 8'h80, 8'h00};
    logic       vc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] es [4] = '{8'h00, 8'h00, 8'h01, 8'h80};
    logic       ec [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], s, co, lat, bcnt);
      checks++; if (s !== es[i]) begin errors++; $display("FAIL carry_sum[%0d] got %h exp %h", i, s, es[i]); end
      checks++; if (co !== ec[i]) begin errors++; $display("FAIL carry_cout[%0d] got %b exp %b", i, co, ec[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int nd = 0; int d0 = 0; int d1 = 0; int guard = 0;
    logic [7:0] s0 = '0; logic [7:0] s1 = '0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        if (nd == 0) begin d0 = i; s0 = bus8.sum; end
        else if (nd == 1) begin d1 = i; s1 = bus8.sum; end
        nd++;
      end
    end
    bus8.start = 1'b0;
    checks++; if (nd !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", nd); end
    checks++; if (d0 !== 9) begin errors++; $display("FAIL b2b_first_done got %0d exp 9", d0); end
    checks++; if (d1 !== 18) begin errors++; $display("FAIL b2b_second_done got %0d exp 18", d1); end
    checks++; if (s0 !== 8'h02) begin errors++; $display("FAIL b2b_sum0 got %h exp 02", s0); end
    checks++; if (s1 !== 8'h02) begin errors++; $display("FAIL b2b_sum1 got %h exp 02", s1); end
    // drain the third add that started on the second done cycle
    while (!bus8.done && guard < 20) begin @(negedge clk); guard++; end
    checks++; if (bus8.done !== 1'b1) begin errors++; $display("FAIL b2b_drain_timeout got %b exp 1", bus8.done); end
  endtask

  task automatic test_ignore_start();
    int lat = 1;
    logic [7:0] mid_sum = '0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    while (!bus8.done && lat < 40) begin
      if (lat == 3) begin bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; end
      else bus8.start = 1'b0;
      if (lat == 5) mid_sum = bus8.sum;
      @(negedge clk);
      lat++;
    end
    bus8.start = 1'b0;
    checks++; if (mid_sum !== 8'h02) begin errors++; $display("FAIL ignore_mid_sum got %h exp 02", mid_sum); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL ignore_latency got %0d exp 9", lat); end
    checks++; if (bus8.sum !== 8'h46) begin errors++; $display("FAIL ignore_sum got %h exp 46", bus8.sum); end
    checks++; if (bus8.cout !== 1'b0) begin errors++; $display("FAIL ignore_cout got %b exp 0", bus8.cout); end
    repeat (2) @(negedge clk);
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy got %b exp 0", bus8.busy); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", bus8.busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus8.busy); end
    checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", bus8.done); end
    checks++; if (bus8.sum !== 8'h00) begin errors++; $display("FAIL rstmid_sum got %h exp 00", bus8.sum); end
    checks++; if (bus8.cout !== 1'b0) begin errors++; $display("FAIL rstmid_cout got %b exp 0", bus8.cout); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus8.done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", seen); end
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [4:0] exp_v;
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          exp_v = 5'(ai) + 5'(bi) + 5'(ci);
          @(negedge clk);
          bus4.start = 1'b1; bus4.a = 4'(ai); bus4.b = 4'(bi); bus4.cin = 1'(ci);
          @(negedge clk);
          bus4.start = 1'b0; bus4.a = 4'(~ai); bus4.b = 4'(~bi);
          lat = 1;
          while (!bus4.done && lat < 20) begin @(negedge clk); lat++; end
          checks++;
          if ({bus4.cout, bus4.sum} !== exp_v || lat !== 5) begin
            errors++;
            $display("FAIL exh4 a=%0d b=%0d cin=%0d got %0d lat %0d exp %0d lat 5",
                     ai, bi, ci, {bus4.cout, bus4.sum}, lat, exp_v);
          end
        end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_exhaustive4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
